// File: rtl/latch_wr_sched_pkg.sv
// Shared definitions for the latch write scheduler: FSM state and grant encodings.
package latch_wr_sched_pkg;

    // Scheduler phases; every write walks SETUP -> PULSE -> HOLD and returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Grant encodings, also used as the bit index of each side in req/gnt vectors.
    localparam int GNT_A = 0;
    localparam int GNT_B = 1;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_wr_sched_rr_arb2.sv
// Two-input round-robin arbiter; the side not granted last time wins a tie.
module rr_arb2
    import latch_wr_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Index of the side granted most recently.
    logic last_gnt;

    // Grant is combinational so ready can be returned in the request cycle.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_gnt == 1'(GNT_B)) ? 2'b01 : 2'b10;
        end
    end

    // Move the pointer only when a grant is actually consumed.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and uses <= like all state.
        if (rst) begin
            last_gnt <= 1'(GNT_B);
        end else if (advance && (gnt != 2'b00)) begin
            last_gnt <= gnt[GNT_B];
        end
    end

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a bank of D-latches: arbitrates two requesters and drives
// data/enable with a setup -> enable pulse -> hold sequence from flops only.
module latch_wr_sched
    import latch_wr_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    input  logic [WIDTH-1:0]         a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    input  logic [WIDTH-1:0]         b_data,
    output logic                     b_ready,
    output logic                     done,
    output logic                     busy,
    output logic [WIDTH-1:0]         lat_d,
    output logic [DEPTH-1:0]         lat_c
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(max3(SETUP, PULSE, HOLD) + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t SETUP_LAST = cnt_t'(SETUP - 1);
    localparam cnt_t PULSE_LAST = cnt_t'(PULSE - 1);
    localparam cnt_t HOLD_LAST  = cnt_t'(HOLD - 1);
    // Counter value one cycle before the final HOLD cycle (only meaningful when HOLD > 1).
    localparam cnt_t HOLD_PRE   = cnt_t'((HOLD > 1) ? HOLD - 2 : 0);

    state_e           state;
    cnt_t             cnt;
    logic [AW-1:0]    cap_addr;
    logic [1:0]       gnt;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [DEPTH-1:0] pulse_onehot;

    // Requests are only taken in IDLE and never while reset is held.
    assign accept  = (state == ST_IDLE) && !rst;
    assign a_ready = accept && gnt[GNT_A];
    assign b_ready = accept && gnt[GNT_B];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_valid, a_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    // Winner's address and data, sampled on the accepting edge.
    assign sel_addr = gnt[GNT_B] ? b_addr : a_addr;
    assign sel_data = gnt[GNT_B] ? b_data : a_data;

    // Address decoder for the captured target register.
    always_comb begin
        pulse_onehot           = '0;
        pulse_onehot[cap_addr] = 1'b1;
    end

    // Phase FSM with registered bus, enable, done and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            lat_d    <= '0;
            lat_c    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (a_ready || b_ready) begin
                        state    <= ST_SETUP;
                        cnt      <= '0;
                        cap_addr <= sel_addr;
                        lat_d    <= sel_data;
                        busy     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= ST_PULSE;
                        cnt   <= '0;
                        lat_c <= pulse_onehot;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        lat_c <= '0;
                        done  <= (HOLD == 1);
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt  <= cnt + cnt_t'(1);
                        done <= (cnt == HOLD_PRE);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: a default-parameter instance (u0) and a
// SETUP=3/PULSE=1/HOLD=2 instance (u1), checked every cycle against an
// age-based transaction model plus directed literal expectations.
module tb_latch_wr_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       a_valid, b_valid, a_ready, b_ready, done, busy;
    logic [1:0][1:0]  a_addr, b_addr;
    logic [1:0][7:0]  a_data, b_data, lat_d;
    logic [1:0][3:0]  lat_c;

    always #5 clk = ~clk;

    latch_wr_sched u0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[0]), .a_addr(a_addr[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_addr(b_addr[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
        .done(done[0]), .busy(busy[0]), .lat_d(lat_d[0]), .lat_c(lat_c[0])
    );

    latch_wr_sched #(.WIDTH(8), .DEPTH(4), .SETUP(3), .PULSE(1), .HOLD(2)) u1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[1]), .a_addr(a_addr[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_addr(b_addr[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
        .done(done[1]), .busy(busy[1]), .lat_d(lat_d[1]), .lat_c(lat_c[1])
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit model_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction model: a write is described only by its age in cycles since acceptance.
    typedef struct {
        int       age;
        int       addr;
        logic [7:0] d;
        bit       last_b;
    } mdl_t;

    mdl_t m [2];
    localparam int MS [2] = '{1, 3};
    localparam int MP [2] = '{2, 1};
    localparam int MH [2] = '{1, 2};

    // 0 = no grant, 1 = A, 2 = B
    function automatic int exp_gnt(input int i);
        if (rst || m[i].age != 0) return 0;
        if (a_valid[i] && b_valid[i]) return m[i].last_b ? 1 : 2;
        if (a_valid[i]) return 1;
        if (b_valid[i]) return 2;
        return 0;
    endfunction

    // Advance the model on every rising edge from the inputs seen before it.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int g;
            g = exp_gnt(i);
            if (rst) begin
                m[i] = '{0, 0, 8'h00, 1'b1};
            end else if (m[i].age != 0) begin
                m[i].age = (m[i].age == MS[i] + MP[i] + MH[i]) ? 0 : m[i].age + 1;
            end else if (g == 1) begin
                m[i] = '{1, int'(a_addr[i]), a_data[i], 1'b0};
            end else if (g == 2) begin
                m[i] = '{1, int'(b_addr[i]), b_data[i], 1'b1};
            end
        end
    end

    logic [1:0][3:0] prev_c;
    logic [1:0][7:0] prev_d;

    // Compare every output of both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < 2; i++) begin
                int a;
                int g;
                logic [3:0] ec;
                a  = m[i].age;
                g  = exp_gnt(i);
                ec = (a > MS[i] && a <= MS[i] + MP[i]) ? 4'(1 << m[i].addr) : 4'b0000;
                check($sformatf("u%0d lat_c", i), 32'(lat_c[i]), 32'(ec));
                check($sformatf("u%0d lat_d", i), 32'(lat_d[i]), 32'(m[i].d));
                check($sformatf("u%0d done", i), 32'(done[i]), 32'(a == MS[i] + MP[i] + MH[i]));
                check($sformatf("u%0d busy", i), 32'(busy[i]), 32'(a != 0));
                check($sformatf("u%0d a_ready", i), 32'(a_ready[i]), 32'(g == 1));
                check($sformatf("u%0d b_ready", i), 32'(b_ready[i]), 32'(g == 2));
                check($sformatf("u%0d lat_c onehot", i), 32'($countones(lat_c[i]) <= 1), 32'd1);
                if (prev_c[i] != 4'b0000 && lat_c[i] != 4'b0000)
                    check($sformatf("u%0d lat_d stable", i), 32'(lat_d[i]), 32'(prev_d[i]));
                prev_c[i] = lat_c[i];
                prev_d[i] = lat_d[i];
            end
        end
    end

    // Grant log for the alternation test (instance u0).
    bit gl_on = 1'b0;
    int gl_side [$];
    int gl_cyc [$];

    always @(negedge clk) begin
        if (gl_on && a_ready[0]) begin gl_side.push_back(0); gl_cyc.push_back(cyc); end
        if (gl_on && b_ready[0]) begin gl_side.push_back(1); gl_cyc.push_back(cyc); end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the side's ready; c0 is the accept cycle; drops valid afterwards.
    task automatic wait_ready(input int i, input bit sb, output int c0);
        bit got;
        got = 1'b0;
        c0  = -1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (sb ? b_ready[i] : a_ready[i]) begin
                got = 1'b1;
                c0  = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (sb) b_valid[i] = 1'b0;
        else    a_valid[i] = 1'b0;
        check($sformatf("u%0d ready seen side %0d", i, sb), 32'(got), 32'd1);
    endtask

    // Literal per-cycle expectations for cycles c0+1 .. c0+done_k of one write.
    task automatic check_write(input int i, input string name, input logic [3:0] oh,
                               input logic [7:0] data, input int c_first, input int c_last,
                               input int done_k);
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            check($sformatf("%s lat_c k%0d", name, k), 32'(lat_c[i]),
                  (k >= c_first && k <= c_last) ? 32'(oh) : 32'd0);
            check($sformatf("%s lat_d k%0d", name, k), 32'(lat_d[i]), 32'(data));
            check($sformatf("%s done k%0d", name, k), 32'(done[i]), 32'(k == done_k));
            check($sformatf("%s busy k%0d", name, k), 32'(busy[i]), 32'd1);
        end
    endtask

    task automatic drive_random(input int i, input bit sb, input int n);
        int c0;
        for (int j = 0; j < n; j++) begin
            if (sb) begin
                b_addr[i] = 2'($urandom_range(0, 3));
                b_data[i] = 8'($urandom_range(0, 255));
                b_valid[i] = 1'b1;
            end else begin
                a_addr[i] = 2'($urandom_range(0, 3));
                a_data[i] = 8'($urandom_range(0, 255));
                a_valid[i] = 1'b1;
            end
            wait_ready(i, sb, c0);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        int c0;
        int c1;
        int r0;
        a_valid = '0; b_valid = '0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        prev_c = '0; prev_d = '0;
        for (int i = 0; i < 2; i++) m[i] = '{0, 0, 8'h00, 1'b1};

        // Reset held for two edges with A requesting.
        rst = 1'b1;
        a_valid[0] = 1'b1; a_addr[0] = 2'd1; a_data[0] = 8'h11;
        step();
        model_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst lat_c", 32'(lat_c[0]), 32'd0);
            check("rst lat_d", 32'(lat_d[0]), 32'd0);
            check("rst a_ready", 32'(a_ready[0]), 32'd0);
            check("rst busy", 32'(busy[0]), 32'd0);
            step();
        end
        rst = 1'b0;
        r0  = cyc;
        wait_ready(0, 1'b0, c0);
        check("first ready after rst", 32'(c0), 32'(r0));
        repeat (5) step();

        // Single write: A, addr 2, data 0x5A.
        a_valid[0] = 1'b1; a_addr[0] = 2'd2; a_data[0] = 8'h5A;
        wait_ready(0, 1'b0, c0);
        check_write(0, "single", 4'b0100, 8'h5A, 2, 3, 4);
        @(negedge clk);
        check("single idle busy", 32'(busy[0]), 32'd0);
        step();

        // Tie after reset, then continuous alternation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        gl_on = 1'b1;
        a_valid[0] = 1'b1; a_addr[0] = 2'd0; a_data[0] = 8'hA0;
        b_valid[0] = 1'b1; b_addr[0] = 2'd3; b_data[0] = 8'hB3;
        repeat (21) step();
        a_valid[0] = 1'b0; b_valid[0] = 1'b0;
        gl_on = 1'b0;
        repeat (6) step();
        check("alt grant count", 32'(gl_side.size() >= 4), 32'd1);
        if (gl_side.size() >= 4) begin
            check("tie first grant", 32'(gl_side[0]), 32'd0);
            check("alt grant 1", 32'(gl_side[1]), 32'd1);
            check("alt grant 2", 32'(gl_side[2]), 32'd0);
            check("alt grant 3", 32'(gl_side[3]), 32'd1);
            for (int j = 1; j < 4; j++)
                check($sformatf("alt spacing %0d", j), 32'(gl_cyc[j] - gl_cyc[j-1]), 32'd5);
        end

        // Randomized back-to-back traffic from both sides.
        fork
            drive_random(0, 1'b0, 12);
            drive_random(0, 1'b1, 12);
        join
        repeat (8) step();

        // Reset in the first PULSE cycle of a write to addr 1.
        a_valid[0] = 1'b1; a_addr[0] = 2'd1; a_data[0] = 8'h3C;
        wait_ready(0, 1'b0, c0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("abort pulse lat_c", 32'(lat_c[0]), 32'b0010);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort lat_c", 32'(lat_c[0]), 32'd0);
        check("abort done", 32'(done[0]), 32'd0);
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort lat_d", 32'(lat_d[0]), 32'd0);
        step();
        b_valid[0] = 1'b1; b_addr[0] = 2'd3; b_data[0] = 8'hC3;
        wait_ready(0, 1'b1, c0);
        check_write(0, "after abort", 4'b1000, 8'hC3, 2, 3, 4);
        repeat (3) step();

        // Parameter sweep instance: two back-to-back writes give the period.
        a_valid[1] = 1'b1; a_addr[1] = 2'd0; a_data[1] = 8'h81;
        wait_ready(1, 1'b0, c0);
        a_valid[1] = 1'b1; a_addr[1] = 2'd3; a_data[1] = 8'h7E;
        check_write(1, "sweep", 4'b0001, 8'h81, 4, 4, 6);
        wait_ready(1, 1'b0, c1);
        check("sweep period", 32'(c1 - c0), 32'd7);
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
